// File: rtl/timebase_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel timebase.
package timebase_pkg;

  // Decoded encoder step direction.
  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

  // Width of the half_cycles() result; callers truncate to their own DIV_W.
  localparam int unsigned HALF_W = 32;

  // Cycles spent in each ADC_clk phase for timebase index b: 4**b.
  function automatic logic [HALF_W-1:0] half_cycles(input int unsigned b);
    return HALF_W'(1) << (2 * b);
  endfunction

  // Counter width needed to reach half_cycles(max index) - 1.
  function automatic int unsigned min_div_w(input int unsigned base_w);
    return 2 * ((1 << base_w) - 1) + 1;
  endfunction

  // True when the parameter set is self-consistent.
  function automatic bit params_ok(input int unsigned base_w,
                                   input int unsigned div_w,
                                   input int unsigned deb_cyc,
                                   input int unsigned base_rst);
    return (div_w >= min_div_w(base_w)) &&
           (min_div_w(base_w) <= HALF_W) &&
           (deb_cyc >= 1) &&
           (base_rst < (1 << base_w));
  endfunction

endpackage

// File: rtl/timebase_chan.sv
// One timebase channel: synchronise and debounce the encoder, decode steps
// into a pending index, and divide clk into a glitch-free ADC sample clock.
module timebase_chan
  import timebase_pkg::*;
#(
  parameter int BASE_W   = 3,
  parameter int DIV_W    = 24,
  parameter int DEB_CYC  = 4,
  parameter int WRAP     = 0,
  parameter int BASE_RST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              quad_a,
  input  logic              quad_b,
  input  logic              en_clk,
  output logic              adc_clk,
  output logic              adc_stb,
  output logic [BASE_W-1:0] base,
  output logic              base_chg
);

  localparam int                RUN_W    = $clog2(DEB_CYC + 1);
  localparam logic [RUN_W-1:0]  RUN_DONE = RUN_W'(DEB_CYC);
  localparam logic [BASE_W-1:0] BASE_MAX = '1;
  localparam logic [BASE_W-1:0] BASE_INI = BASE_W'(BASE_RST);

  // Bit 0 carries phase A, bit 1 phase B throughout the input path.
  logic [1:0]       sync1, sync2, last, acc;
  logic [RUN_W-1:0] run_q   [2];
  logic [RUN_W-1:0] run_nxt [2];
  logic             acc_a_d;
  dir_t             step;
  logic [BASE_W-1:0] pend, pend_nxt;
  logic [DIV_W-1:0]  cnt, half_m1;
  logic              terminal, apply;

  // Two-flop synchroniser for the asynchronous encoder phases.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so each flop samples its pre-edge input; blocking would collapse the two stages into one.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {quad_b, quad_a};
      sync2 <= sync1;
    end
  end

  // Length of the current run of identical synchronised samples, saturating at DEB_CYC.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: default assigned first so every path drives run_nxt and no latch is inferred.
      run_nxt[i] = run_q[i];
      if (sync2[i] != last[i])        run_nxt[i] = RUN_W'(1);
      else if (run_q[i] != RUN_DONE)  run_nxt[i] = run_q[i] + RUN_W'(1);
    end
  end

  // Accept a phase value once it has been seen DEB_CYC samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= '0;
      acc     <= '0;
      acc_a_d <= 1'b0;
      // NOTE: run_q is a two-entry register array, not a RAM, so it is reset like any other flop.
      for (int i = 0; i < 2; i++) run_q[i] <= '0;
    end else begin
      last    <= sync2;
      acc_a_d <= acc[0];
      for (int i = 0; i < 2; i++) begin
        run_q[i] <= run_nxt[i];
        if (run_nxt[i] == RUN_DONE) acc[i] <= sync2[i];
      end
    end
  end

  // Only an accepted A rising edge is a step; B selects the direction.
  always_comb begin
    step = DIR_NONE;
    if (acc[0] && !acc_a_d) step = acc[1] ? DIR_DN : DIR_UP;
  end

  // Pending index after this step, saturating or wrapping at the ends.
  always_comb begin
    pend_nxt = pend;
    unique case (step)
      DIR_UP: begin
        if (pend != BASE_MAX) pend_nxt = pend + BASE_W'(1);
        else if (WRAP != 0)   pend_nxt = '0;
      end
      DIR_DN: begin
        if (pend != '0)       pend_nxt = pend - BASE_W'(1);
        else if (WRAP != 0)   pend_nxt = BASE_MAX;
      end
      default: ;
    endcase
  end

  // Terminal count of the current phase and the point where base may change.
  assign half_m1  = DIV_W'(half_cycles(32'(base)) - 1);
  assign terminal = en_clk && (cnt == half_m1);
  // While running, only the falling toggle (period end) may switch base.
  assign apply    = en_clk ? (terminal && adc_clk) : 1'b1;

  // Divider: toggle ADC_clk every half(base) cycles, strobe on the rising toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
      adc_stb <= 1'b0;
    end else if (!en_clk) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
      adc_stb <= 1'b0;
    end else if (terminal) begin
      cnt     <= '0;
      adc_clk <= ~adc_clk;
      adc_stb <= ~adc_clk;
    end else begin
      cnt     <= cnt + DIV_W'(1);
      adc_stb <= 1'b0;
    end
  end

  // Index registers: steps accumulate in pend, base takes pend only at apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= BASE_INI;
      base     <= BASE_INI;
      base_chg <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      base_chg <= apply && (pend != base);
      if (apply) base <= pend;
    end
  end

endmodule

// File: rtl/timebase_multi.sv
// N-channel timebase controller: independent encoder-driven ADC clock
// dividers sharing only clk50 and rst.
module timebase_multi
  import timebase_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BASE_W   = 3,
  parameter int DIV_W    = 24,
  parameter int DEB_CYC  = 4,
  parameter int WRAP     = 0,
  parameter int BASE_RST = 0
) (
  input  logic                     clk50,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        quadA,
  input  logic [NUM_CH-1:0]        quadB,
  input  logic [NUM_CH-1:0]        en_clk,
  output logic [NUM_CH-1:0]        ADC_clk,
  output logic [NUM_CH-1:0]        ADC_stb,
  output logic [NUM_CH*BASE_W-1:0] base,
  output logic [NUM_CH-1:0]        base_chg,
  output logic                     dev_clk
);

  if (!params_ok(BASE_W, DIV_W, DEB_CYC, BASE_RST)) begin : g_param_err
    $error("timebase_multi: DIV_W too small, DEB_CYC < 1 or BASE_RST out of range");
  end

  assign dev_clk = clk50;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timebase_chan #(
      .BASE_W  (BASE_W),
      .DIV_W   (DIV_W),
      .DEB_CYC (DEB_CYC),
      .WRAP    (WRAP),
      .BASE_RST(BASE_RST)
    ) u_chan (
      .clk     (clk50),
      .rst     (rst),
      .quad_a  (quadA[i]),
      .quad_b  (quadB[i]),
      .en_clk  (en_clk[i]),
      .adc_clk (ADC_clk[i]),
      .adc_stb (ADC_stb[i]),
      .base    (base[i*BASE_W +: BASE_W]),
      .base_chg(base_chg[i])
    );
  end

endmodule
